// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-stage definitions: address width, default vectors and the
// program-counter FSM state type.
package rv32i_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [RV_XLEN-1:0] RV_RESET_VECTOR = 32'h0000_0000;
  localparam logic [RV_XLEN-1:0] RV_TRAP_VECTOR  = 32'h0000_0010;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_hist_pipe.sv
// PC history shift register: stage 0 is youngest. Each stage holds {valid, pc}.
// Shift, wrong-path kill of the youngest stages, and flush of all valid bits.
module pc_hist_pipe
  import rv32i_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int DEPTH = 2,
  parameter int KILL  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_shift,
  input  logic                  i_kill,
  input  logic                  i_flush,
  input  logic [XLEN-1:0]       i_pc,
  input  logic                  i_valid,
  output logic [DEPTH*XLEN-1:0] o_pc,
  output logic [DEPTH-1:0]      o_valid
);

  localparam logic [DEPTH-1:0] KILL_MASK = DEPTH'((64'd1 << KILL) - 64'd1);

  logic [XLEN-1:0]  r_pc [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] w_valid_next;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_valid_next = r_valid;
    if (i_shift) begin
      w_valid_next = (r_valid << 1) | DEPTH'(i_valid);
      if (i_kill) begin
        w_valid_next = w_valid_next & ~KILL_MASK;
      end
    end
    if (i_flush) begin
      w_valid_next = '0;
    end
  end

  // NOTE: the PC storage is reset too, because downstream logic expects hist_pc to read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i] <= '0;
      end
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_next;
      if (i_shift) begin
        r_pc[0] <= i_pc;
        for (int i = 1; i < DEPTH; i++) begin
          r_pc[i] <= r_pc[i-1];
        end
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_out
    assign o_pc[g*XLEN +: XLEN] = r_pc[g];
  end

  assign o_valid = r_valid;

endmodule

// File: rtl/pc_gen.sv
// RV32I fetch program-counter generator: BOOT/RUN FSM, redirect-over-stall
// priority, misaligned-target trap, and a per-stage PC history pipe.
module pc_gen
  import rv32i_pkg::*;
#(
  parameter int              XLEN         = RV_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RV_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(RV_TRAP_VECTOR),
  parameter int              INC          = 4,
  parameter int              HIST_DEPTH   = 2,
  parameter int              KILL_DEPTH   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       jump_sel,
  input  logic                       branch_taken,
  input  logic [XLEN-1:0]            next_address,
  input  logic                       flush,
  output logic [XLEN-1:0]            pc_out,
  output logic                       pc_valid,
  output logic [HIST_DEPTH*XLEN-1:0] hist_pc,
  output logic [HIST_DEPTH-1:0]      hist_valid,
  output logic                       misalign_err
);

  localparam logic [XLEN-1:0] INC_MASK = XLEN'(INC - 1);

  pc_state_e       r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_misalign;

  logic w_run;
  logic w_redirect;
  logic w_misaligned;

  assign w_run        = (r_state == RUN);
  assign w_redirect   = jump_sel | branch_taken;
  assign w_misaligned = |(next_address & INC_MASK);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_VECTOR;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state    <= RUN;
          r_valid    <= 1'b1;
          r_misalign <= 1'b0;
        end
        RUN: begin
          r_misalign <= 1'b0;
          // A redirect wins over stall: the execute stage has already resolved it.
          if (w_redirect) begin
            if (w_misaligned) begin
              r_pc       <= TRAP_VECTOR;
              r_misalign <= 1'b1;
            end else begin
              r_pc <= next_address;
            end
          end else if (!stall) begin
            r_pc <= r_pc + XLEN'(INC);
          end
        end
      endcase
    end
  end

  pc_hist_pipe #(
    .XLEN  (XLEN),
    .DEPTH (HIST_DEPTH),
    .KILL  (KILL_DEPTH)
  ) u_hist (
    .clk     (clk),
    .rst_n   (rst),
    .i_shift (w_run & (~stall | w_redirect)),
    .i_kill  (w_run & w_redirect),
    .i_flush (flush),
    .i_pc    (r_pc),
    .i_valid (r_valid),
    .o_pc    (hist_pc),
    .o_valid (hist_valid)
  );

  assign pc_out       = r_pc;
  assign pc_valid     = r_valid;
  assign misalign_err = r_misalign;

endmodule
